// File: rtl/ws2812_pkg.sv
// Shared WS2812 definitions: line-state encoding, GRB field layout, timing derivation.
// Latency: none (types, constants and constant functions only).
// Backpressure: not applicable.
package ws2812_pkg;

   // Receiver line state: SYNC waits for a latch, OWN captures, FWD forwards.
   typedef enum logic [1:0] {
      ST_SYNC = 2'd0,
      ST_OWN  = 2'd1,
      ST_FWD  = 2'd2
   } ws_state_t;

   // Bit positions of the colour fields inside a 24-bit {G,R,B} word.
   localparam int GRB_FIELD_W = 8;
   localparam int GRB_G_LSB   = 16;
   localparam int GRB_R_LSB   = 8;
   localparam int GRB_B_LSB   = 0;

   function automatic int cyc_per_us(input int clk_hz);
      return clk_hz / 1_000_000;
   endfunction

   function automatic int ns_to_cyc(input int clk_hz, input int ns);
      return (cyc_per_us(clk_hz) * ns) / 1000;
   endfunction

   // Same as ns_to_cyc but never below one cycle, so a threshold cannot vanish.
   function automatic int ns_to_cyc_min1(input int clk_hz, input int ns);
      int c;
      c = ns_to_cyc(clk_hz, ns);
      return (c < 1) ? 1 : c;
   endfunction

   function automatic int us_to_cyc(input int clk_hz, input int us);
      return cyc_per_us(clk_hz) * us;
   endfunction

endpackage

// File: rtl/ws2812_pulse_meas.sv
// Synchronises the WS2812 line, measures high/low widths and classifies pulses and latches.
// Latency: 2 cycles synchroniser; fall/latch/too_long are flagged in the cycle the condition appears on din_s.
// Backpressure: none; the line is free-running and every event is a single-cycle strobe.
module ws2812_pulse_meas
   import ws2812_pkg::*;
#(
   parameter int CLK_HZ    = 27_000_000,
   parameter int THR_NS    = 525,
   parameter int GLITCH_NS = 100,
   parameter int TRES_US   = 50,
   parameter int THMAX_US  = 2
) (
   input  logic clk_g,
   input  logic rst_n,
   input  logic ws2812_din,
   output logic din_s,
   output logic fall,
   output logic bit_val,
   output logic glitch,
   output logic latch,
   output logic too_long
);

   localparam logic [15:0] THR   = 16'(ns_to_cyc(CLK_HZ, THR_NS));
   localparam logic [15:0] GLT   = 16'(ns_to_cyc_min1(CLK_HZ, GLITCH_NS));
   localparam logic [15:0] TRES  = 16'(us_to_cyc(CLK_HZ, TRES_US));
   localparam logic [15:0] THMAX = 16'(us_to_cyc(CLK_HZ, THMAX_US));

   logic        din_m;
   logic        din_d;
   logic        rise;
   logic [15:0] hi_cnt;
   logic [15:0] lo_cnt;

   // Two-flop synchroniser plus one delayed copy for edge detection.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         din_m <= 1'b0;
         din_s <= 1'b0;
         din_d <= 1'b0;
      end else begin
         din_m <= ws2812_din;
         din_s <= din_m;
         din_d <= din_s;
      end
   end

   assign rise = din_s & ~din_d;
   assign fall = ~din_s & din_d;

   // High-width counter; holds through the low phase so it equals the pulse width at the fall.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         hi_cnt <= '0;
      end else if (rise) begin
         hi_cnt <= 16'd1;
      end else if (din_s && (hi_cnt != 16'hFFFF)) begin
         hi_cnt <= hi_cnt + 16'd1;
      end
   end

   // Low-width counter; saturating at TRES makes the latch strobe fire once per low period.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         lo_cnt <= '0;
      end else if (din_s) begin
         lo_cnt <= '0;
      end else if (lo_cnt != TRES) begin
         lo_cnt <= lo_cnt + 16'd1;
      end
   end

   assign bit_val  = (hi_cnt >= THR);
   assign glitch   = (hi_cnt < GLT);
   assign latch    = ~din_s & (lo_cnt == (TRES - 16'd1));
   assign too_long = din_s & (hi_cnt > THMAX);

endmodule

// File: rtl/ws2812_rx_pixel.sv
// WS2812 pixel receiver: captures the first 24 bits after a latch, forwards the rest downstream.
// Latency: color_grb/pixel_valid one cycle after the 24th fall on din_s; ws2812_dout is din 3 cycles late.
// Backpressure: none; the serial stream cannot be stalled, so outputs are single-cycle strobes.
module ws2812_rx_pixel
   import ws2812_pkg::*;
#(
   parameter int CLK_HZ    = 27_000_000,
   parameter int THR_NS    = 525,
   parameter int GLITCH_NS = 100,
   parameter int TRES_US   = 50,
   parameter int THMAX_US  = 2
) (
   input  logic        clk_g,
   input  logic        rst_n,
   input  logic        ws2812_din,
   output logic        ws2812_dout,
   output logic [23:0] color_grb,
   output logic        pixel_valid,
   output logic        frame_end,
   output logic        bit_err
);

   logic       din_s;
   logic       fall;
   logic       bit_val;
   logic       glitch;
   logic       latch;
   logic       too_long;

   ws_state_t   state;
   ws_state_t   state_nxt;
   logic [4:0]  bit_cnt;
   logic [4:0]  bit_cnt_nxt;
   logic [23:0] shreg;
   logic [23:0] shreg_nxt;
   logic        cap;
   logic        fe;
   logic        err_set;
   logic        err_clr;
   logic        fwd_en;

   ws2812_pulse_meas #(
      .CLK_HZ    (CLK_HZ),
      .THR_NS    (THR_NS),
      .GLITCH_NS (GLITCH_NS),
      .TRES_US   (TRES_US),
      .THMAX_US  (THMAX_US)
   ) u_meas (
      .clk_g      (clk_g),
      .rst_n      (rst_n),
      .ws2812_din (ws2812_din),
      .din_s      (din_s),
      .fall       (fall),
      .bit_val    (bit_val),
      .glitch     (glitch),
      .latch      (latch),
      .too_long   (too_long)
   );

   // State register.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_SYNC;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state and capture decisions; an over-long high beats a latch, which beats a bit.
   always_comb begin
      state_nxt   = state;
      bit_cnt_nxt = bit_cnt;
      shreg_nxt   = shreg;
      cap         = 1'b0;
      fe          = 1'b0;
      err_set     = 1'b0;
      err_clr     = 1'b0;
      if (too_long) begin
         state_nxt = ST_SYNC;
         err_set   = 1'b1;
      end else if (latch) begin
         fe          = 1'b1;
         state_nxt   = ST_OWN;
         bit_cnt_nxt = 5'd0;
         // A latch cutting off a partly received pixel is an error; otherwise a new frame starts clean.
         if ((state == ST_OWN) && (bit_cnt != 5'd0)) begin
            err_set = 1'b1;
         end else begin
            err_clr = 1'b1;
         end
      end else if ((state == ST_OWN) && fall) begin
         if (glitch) begin
            err_set = 1'b1;
         end else begin
            shreg_nxt = {shreg[22:0], bit_val};
            if (bit_cnt == 5'd23) begin
               cap         = 1'b1;
               bit_cnt_nxt = 5'd0;
               state_nxt   = ST_FWD;
            end else begin
               bit_cnt_nxt = bit_cnt + 5'd1;
            end
         end
      end
   end

   // Capture datapath, event strobes and the sticky error flag.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         bit_cnt     <= '0;
         shreg       <= '0;
         color_grb   <= '0;
         pixel_valid <= 1'b0;
         frame_end   <= 1'b0;
         bit_err     <= 1'b0;
      end else begin
         bit_cnt     <= bit_cnt_nxt;
         shreg       <= shreg_nxt;
         pixel_valid <= cap;
         frame_end   <= fe;
         if (cap) begin
            color_grb <= shreg_nxt;
         end
         if (err_set) begin
            bit_err <= 1'b1;
         end else if (err_clr) begin
            bit_err <= 1'b0;
         end
      end
   end

   // Forwarding: only after din_s has been seen low in FWD, so a pulse already in progress is never cut.
   always_ff @(posedge clk_g or negedge rst_n) begin
      if (!rst_n) begin
         fwd_en      <= 1'b0;
         ws2812_dout <= 1'b0;
      end else begin
         fwd_en      <= (state == ST_FWD) && (fwd_en || !din_s);
         ws2812_dout <= (state == ST_FWD) && fwd_en && din_s && !too_long;
      end
   end

endmodule

// File: doc/ws2812_rx_pixel.md
WS2812_RX_PIXEL -- requirements
Module: ws2812_rx_pixel

Interface
REQ-001 SHALL have parameter CLK_HZ, default 27_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter THR_NS, default 525, high-time threshold separating a 0 bit from a 1 bit.
REQ-003 SHALL have parameter GLITCH_NS, default 100; high pulses shorter than this are discarded.
REQ-004 SHALL have parameter TRES_US, default 50, minimum low time recognised as a latch/reset.
REQ-005 SHALL have parameter THMAX_US, default 2, maximum legal high time.
REQ-006 SHALL have port clk_g, input, 1, the single system clock; all logic runs on its rising edge.
REQ-007 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port ws2812_din, input, 1, asynchronous serial WS2812 stream (GRB, MSB first).
REQ-009 SHALL have port ws2812_dout, output, 1, stream forwarded to the next pixel.
REQ-010 SHALL have port color_grb, output, 24, last complete captured pixel value {G,R,B}.
REQ-011 SHALL have port pixel_valid, output, 1, one-cycle pulse when color_grb updates.
REQ-012 SHALL have port frame_end, output, 1, one-cycle pulse on latch detection.
REQ-013 SHALL have port bit_err, output, 1, sticky error flag, cleared at the next frame start.

Function
REQ-014 SHALL pass ws2812_din through a 2-flop synchroniser; all timing uses the synchronised signal din_s.
REQ-015 SHALL derive cycle counts as follows (values at 27 MHz):
- CYC_PER_US = CLK_HZ/1e6
- THR = CYC_PER_US*THR_NS/1000 (14)
- GLT = CYC_PER_US*GLITCH_NS/1000, floor 1 (2)
- TRES = CYC_PER_US*TRES_US (1350)
- THMAX = CYC_PER_US*THMAX_US (54)
REQ-016 SHALL count din_s high cycles in a 16-bit saturating hi_cnt, reset on each rising edge.
REQ-017 SHALL count din_s low cycles in a 16-bit lo_cnt that saturates at TRES.
REQ-018 SHALL implement states SYNC, OWN and FWD; reset enters SYNC.
REQ-019 SYNC SHALL ignore all pulses and go to OWN when lo_cnt reaches TRES, with bit_cnt=0 and bit_err cleared.
REQ-020 In OWN, on each falling edge of din_s:
- hi_cnt < GLT: discard the pulse, set bit_err
- otherwise: shift (hi_cnt >= THR) into a 24-bit shift register and increment bit_cnt
REQ-021 On the 24th accepted bit, the next cycle SHALL load color_grb from the shift register, pulse pixel_valid, and enter FWD.
REQ-022 In FWD, ws2812_dout SHALL equal din_s delayed by one cycle; in SYNC and OWN ws2812_dout SHALL be 0, so own bits are never forwarded.
REQ-023 The first rising edge seen while in FWD SHALL be forwarded intact, with no truncated partial pulse.
REQ-024 In any state, lo_cnt reaching TRES SHALL pulse frame_end for exactly one cycle and return to OWN with bit_cnt=0.
REQ-025 A latch with 0 < bit_cnt < 24 in OWN SHALL discard the partial pixel, leave color_grb unchanged, set bit_err, and not pulse pixel_valid.
REQ-026 hi_cnt exceeding THMAX in any state SHALL set bit_err and force SYNC, with ws2812_dout driven 0 immediately.
REQ-027 frame_end SHALL fire once per low period, not repeatedly while the line stays low.
REQ-028 bit_err SHALL hold until the next entry to OWN from a latch.

Reset
REQ-029 Asserting rst_n low SHALL asynchronously force all outputs to 0 (color_grb=0, pixel_valid=0, frame_end=0, bit_err=0, ws2812_dout=0), clear counters and synchroniser, and enter SYNC.
REQ-030 Reset mid-frame SHALL discard in-flight bits; after deassertion a full TRES low period is required before any capture.

Structure
REQ-031 Shared package ws2812_pkg SHALL hold:
- the timing-derivation functions (cycles from ns/us and CLK_HZ)
- GRB field offsets
- the state encoding
All SHALL be reused by the existing transmit drivers.
REQ-032 Pulse measurement (synchroniser, edge detect, hi_cnt/lo_cnt, classify and latch events) SHALL be a sub-module ws2812_pulse_meas; the top holds the FSM, capture and forwarding.

Verification
REQ-033 Reset, 1350-cycle low, then 24 bits for 0x0A0800 (1 = high 19/low 15, 0 = high 10/low 24) -> pixel_valid one pulse, color_grb=0x0A0800, ws2812_dout stays 0.
REQ-034 Continue with a second pixel 0xFF00FF -> ws2812_dout reproduces its 24 pulses delayed 3 cycles (2 sync + 1), color_grb unchanged; then 1350 low -> one frame_end pulse.
REQ-035 Inject a 1-cycle high glitch between bits 5 and 6 -> bit discarded, bit_err=1, pixel still captured correctly.
REQ-036 Latch after 12 bits -> no pixel_valid, color_grb keeps the prior value, bit_err=1, frame_end pulses.
REQ-037 Hold din high for 60 cycles mid-frame -> bit_err=1, SYNC entered, ws2812_dout=0; pixel captured after the next 1350-cycle low.
REQ-038 Assert rst_n at bit 10 -> outputs 0 asynchronously; no capture until a full latch low is seen.
